opb_register_bank_ppc2simulink: RTL

Parametrised successor to the single-register PPC-to-Simulink OPB slave. It holds NUM_REGS software-writable 32-bit control registers on one OPB slave window, with byte-enable writes, readback and a per-register one-cycle update strobe towards user logic. Everything runs in the OPB clock domain; user logic samples user_data_out and user_we synchronously. An optional shadow/commit mode applies multi-register updates atomically.

---
 rtl/opb_regbank_pkg.sv | 24 ++
 rtl/opb_slave_ack_fsm.sv | 56 +++++
 rtl/opb_register_bank_ppc2simulink.sv | 137 +++++++++++++
 3 files changed

// File: rtl/opb_regbank_pkg.sv
// Shared types, constants and helpers for the OPB register bank.
// Used by opb_slave_ack_fsm and opb_register_bank_ppc2simulink.
package opb_regbank_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;

  typedef logic [1:0] opb_state_t;

  localparam opb_state_t StIdle = 2'd0;
  localparam opb_state_t StAck  = 2'd1;
  localparam opb_state_t StHold = 2'd2;

  // be[3] is OPB BE[0] and selects the most significant byte (user bits 31:24).
  function automatic logic [DATA_W-1:0] be_to_mask(input logic [WORD_BYTES-1:0] be);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode and IDLE/ACK/HOLD sequencing.
// Emits a single-cycle read or write strobe per select, with the word index.
module opb_slave_ack_fsm
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h01188700,
  parameter logic [31:0] HighAddr = 32'h011887FF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic        rnw_i,
  input  logic        select_i,
  input  logic        seq_addr_i,
  output logic        wr_stb_o,
  output logic        rd_stb_o,
  output logic [29:0] idx_o,
  output logic        ack_o
);

  opb_state_t  state_q, state_d;
  logic        hit;
  logic        start;
  logic [31:0] offset;
  logic        unused_offset;

  assign hit           = select_i && (addr_i >= BaseAddr) && (addr_i <= HighAddr);
  assign offset        = addr_i - BaseAddr;
  assign idx_o         = offset[31:2];
  assign unused_offset = ^offset[1:0];

  // Strobes fire during the request cycle so storage updates on the edge that raises ack.
  assign start    = (state_q == StIdle) && hit;
  assign wr_stb_o = start && !rnw_i;
  assign rd_stb_o = start && rnw_i;
  assign ack_o    = (state_q == StAck);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (hit) state_d = StAck;
      StAck:  state_d = StHold;
      StHold: if (!select_i || seq_addr_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// NUM_REGS x 32-bit software-writable register bank on an OPB slave window.
// Define SHADOW_COMMIT_EN to stage writes in shadows and commit them atomically.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01188700,
  parameter logic [31:0] C_HIGHADDR   = 32'h011887FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned NUM_REGS     = 8,
  parameter logic [31:0] RESET_VAL    = 32'h0
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic [NUM_REGS*DATA_W-1:0] user_data_out,
  output logic [NUM_REGS-1:0]        user_we
);

  logic              wr_stb, rd_stb, xfer_ack;
  logic [29:0]       idx;
  logic [31:0]       abus, wdata, wmask;
  logic [3:0]        be;

  // Big-endian OPB buses map straight onto little-endian vectors: bit 0 becomes the MSB.
  assign abus  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign be    = OPB_BE;
  assign wmask = be_to_mask(be);

  opb_slave_ack_fsm #(
    .BaseAddr (C_BASEADDR),
    .HighAddr (C_HIGHADDR)
  ) u_ack_fsm (
    .clk_i      (OPB_Clk),
    .rst_ni     (OPB_Rst_n),
    .addr_i     (abus),
    .rnw_i      (OPB_RNW),
    .select_i   (OPB_select),
    .seq_addr_i (OPB_seqAddr),
    .wr_stb_o   (wr_stb),
    .rd_stb_o   (rd_stb),
    .idx_o      (idx),
    .ack_o      (xfer_ack)
  );

  logic [DATA_W-1:0]   live_q [NUM_REGS];
  logic [DATA_W-1:0]   live_d [NUM_REGS];
  logic [NUM_REGS-1:0] we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef SHADOW_COMMIT_EN
  logic [DATA_W-1:0]   shadow_q [NUM_REGS];
  logic [DATA_W-1:0]   shadow_d [NUM_REGS];

  always_comb begin
    live_d   = live_q;
    shadow_d = shadow_q;
    we_d     = '0;
    rdata_d  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_stb && idx == 30'(i) && be != 4'b0) begin
        shadow_d[i] = (shadow_q[i] & ~wmask) | (wdata & wmask);
      end
      if (rd_stb && idx == 30'(i)) begin
        rdata_d = shadow_q[i];
      end
    end
    // Commit: OPB BE[3] and DBus[31] are the least significant byte enable and bit.
    if (wr_stb && idx == 30'(NUM_REGS) && be[0] && wdata[0]) begin
      live_d = shadow_q;
      we_d   = '1;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= RESET_VAL;
      end
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  always_comb begin
    live_d  = live_q;
    we_d    = '0;
    rdata_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_stb && idx == 30'(i) && be != 4'b0) begin
        live_d[i] = (live_q[i] & ~wmask) | (wdata & wmask);
        we_d[i]   = 1'b1;
      end
      if (rd_stb && idx == 30'(i)) begin
        rdata_d = live_q[i];
      end
    end
  end
`endif

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live_q[i] <= RESET_VAL;
      end
      we_q    <= '0;
      rdata_q <= '0;
    end else begin
      live_q  <= live_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gen_user_out
    assign user_data_out[DATA_W*g +: DATA_W] = live_q[g];
  end

  assign user_we    = we_q;
  assign Sl_DBus    = rdata_q;
  assign Sl_xferAck = xfer_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule
